// File: rtl/demux_1to4_stream_if.sv
// rtl/demux_1to4_stream_if.sv - shared input stream and four lane output streams of the 1:4 demux
interface demux_1to4_stream_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic [1:0]            in_sel;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic [4*DATA_W-1:0]   out_data;
    logic [4*CNT_W-1:0]    out_count;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/demux_1to4_stream.sv
// rtl/demux_1to4_stream.sv - registered 1:4 stream demux with one-entry lane slots
// and per-lane delivered-beat counters.
module demux_1to4_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    demux_1to4_stream_if.slave   bus
);
    logic [3:0]              valid_q, valid_d;
    logic [3:0][DATA_W-1:0]  data_q, data_d;
    logic [3:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]              pop;
    logic                    in_ready;
    logic                    push;

    always_comb begin
        pop      = valid_q & bus.out_ready;
        // Only the selected lane can stall the input; a popping lane frees its slot this cycle.
        in_ready = ~flush & (~valid_q[bus.in_sel] | bus.out_ready[bus.in_sel]);
        push     = bus.in_valid & in_ready;
        valid_d  = valid_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (pop[i]) begin
                valid_d[i] = 1'b0;
                cnt_d[i]   = cnt_q[i] + CNT_W'(1);
            end
            if (push && (bus.in_sel == 2'(i))) begin
                valid_d[i] = 1'b1;
                data_d[i]  = bus.in_data;
            end
            if (flush) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_count = cnt_q;
endmodule

// File: tb/tb_demux_1to4_stream.sv
// tb/tb_demux_1to4_stream.sv - randomized and directed bench for demux_1to4_stream
// against a per-lane queue model of delivered beats.
module tb_demux_1to4_stream;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic clk;
    logic rst_n;
    logic flush;

    demux_1to4_stream_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    demux_1to4_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [DATA_W-1:0] lane_q [4][$];
    int                lane_cnt [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear(input bit counts_too);
        for (int i = 0; i < 4; i++) begin
            lane_q[i].delete();
            if (counts_too) lane_cnt[i] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("valid%0d", i), 64'(bus.out_valid[i]), 64'(lane_q[i].size() != 0));
            if (lane_q[i].size() != 0)
                check($sformatf("data%0d", i), 64'(bus.out_data[i*DATA_W +: DATA_W]), 64'(lane_q[i][0]));
            check($sformatf("count%0d", i), 64'(bus.out_count[i*CNT_W +: CNT_W]),
                  64'(lane_cnt[i] % (1 << CNT_W)));
        end
    endtask

    // One clock cycle: called at a negedge, returns at the following negedge.
    task automatic step(input bit fl, input bit vld, input logic [1:0] sel,
                        input logic [DATA_W-1:0] dat, input logic [3:0] rdy);
        bit exp_ready;
        flush         = fl;
        bus.in_valid  = vld;
        bus.in_sel    = sel;
        bus.in_data   = dat;
        bus.out_ready = rdy;
        #1;
        check_outputs();
        exp_ready = !fl && (lane_q[sel].size() == 0 || rdy[sel]);
        check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        for (int i = 0; i < 4; i++) begin
            if (lane_q[i].size() != 0 && rdy[i]) begin
                void'(lane_q[i].pop_front());
                lane_cnt[i]++;
            end
        end
        if (fl) model_clear(1'b0);
        else if (vld && exp_ready) lane_q[sel].push_back(dat);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        flush = 1'b0; bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = '0; bus.out_ready = 4'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear(1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = '0; bus.out_ready = 4'h0;
        @(negedge clk);
        do_reset();
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'h0);
        check("rst_count", 64'(bus.out_count), 64'h0);
        check("rst_ready", 64'(bus.in_ready), 64'h1);
        @(negedge clk);

        // single steer and head-of-line blocking on the selected lane only
        step(0, 1, 2'd2, 8'hA5, 4'b0000);
        check("steer_valid", 64'(bus.out_valid), 64'b0100);
        check("steer_data", 64'(bus.out_data[2*DATA_W +: DATA_W]), 64'hA5);
        step(0, 1, 2'd2, 8'h77, 4'b0000);
        step(0, 1, 2'd0, 8'h3C, 4'b0000);
        check("steer_two", 64'(bus.out_valid), 64'b0101);

        // full throughput, one beat per cycle round-robin
        do_reset();
        for (int i = 0; i < 16; i++) step(0, 1, 2'(i % 4), 8'(i), 4'b1111);
        step(0, 0, 2'd0, 8'h00, 4'b1111);
        check("thru_count", 64'(bus.out_count), 64'h04040404);

        // same-lane pop and push in one cycle
        do_reset();
        step(0, 1, 2'd1, 8'h11, 4'b0000);
        step(0, 1, 2'd1, 8'h22, 4'b0010);
        check("pp_valid", 64'(bus.out_valid[1]), 64'h1);
        check("pp_data", 64'(bus.out_data[DATA_W +: DATA_W]), 64'h22);
        check("pp_count", 64'(bus.out_count[CNT_W +: CNT_W]), 64'h1);

        // flush with a beat offered
        step(0, 1, 2'd0, 8'h5A, 4'b0000);
        step(0, 1, 2'd3, 8'hC3, 4'b0000);
        step(1, 1, 2'd2, 8'hEE, 4'b0000);
        check("flush_valid", 64'(bus.out_valid), 64'h0);
        check("flush_count", 64'(bus.out_count[CNT_W +: CNT_W]), 64'h1);

        // counter wrap on lane 0
        do_reset();
        for (int i = 0; i < 257; i++) step(0, 1, 2'd0, 8'(i), 4'b0001);
        check("wrap_zero", 64'(bus.out_count[0 +: CNT_W]), 64'h0);
        step(0, 1, 2'd0, 8'hFF, 4'b0001);
        check("wrap_one", 64'(bus.out_count[0 +: CNT_W]), 64'h1);

        // random traffic with an asynchronous reset in the middle
        for (int n = 0; n < 400; n++)
            step(($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'h0);
        check("arst_count", 64'(bus.out_count), 64'h0);
        model_clear(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 400; n++)
            step(($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/demux_1to4_stream.md
Name: demux_1to4_stream

Overview:
- Registered 1-to-4 stream demultiplexer. It is the distributing counterpart of the team's 4:1 byte mux.
- A single valid/ready input stream carries a 2-bit destination select with each beat. Each beat is steered into a one-entry output slot for the selected lane, and that lane presents it on its own valid/ready interface.
- Sits between a shared producer (e.g. a bus or parser) and four independent consumers.
- Keeps a per-lane delivered-beat counter for debug and bench checking.

Parameters:
- DATA_W, 8, width of the data path in bits.
- CNT_W, 8, width of each per-lane delivered-beat counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all lane slots (counters untouched).
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted this cycle when in_valid & in_ready.
- in_data  input  DATA_W  input beat payload.
- in_sel  input  2  destination lane for the beat (0..3).
- out_valid  output  4  per-lane slot valid; bit i = lane i.
- out_ready  input  4  per-lane consumer ready.
- out_data  output  4*DATA_W  lane i payload at bits [i*DATA_W +: DATA_W].
- out_count  output  4*CNT_W  lane i delivered-beat count at [i*CNT_W +: CNT_W].

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low on rst_n.
- Reset state: out_valid=0, out_data=0, out_count=0. in_ready follows its equation below, so it is 1 after reset because every slot is empty.
- Lane slot: each lane has one register holding a valid bit and DATA_W bits of data. Output is driven directly from the slot, with no combinational path from in_data to out_data.
- Lane pop: lane i pops when out_valid[i] & out_ready[i]. On a pop, out_count[i] increments by 1 and wraps from 2^CNT_W-1 to 0.
- Accept condition: in_ready = ~flush & (~out_valid[in_sel] | out_ready[in_sel]).
  - in_ready depends combinationally on in_sel and out_ready; this is intended.
  - Beats for other lanes never block on a full lane: head-of-line blocking applies only to the selected lane.
- Push: on accept, slot[in_sel] loads in_data and sets valid at the next edge. Latency is 1 cycle from accept to out_valid.
- Simultaneous pop and push on the same lane: the new beat replaces the old one, valid stays 1, and the count increments. This gives full throughput of 1 beat/cycle per lane.
- Pop without push: valid clears at the next edge. out_data holds its last value and is don't-care while valid=0; the bench must not check it then.
- Pushes to different lanes in consecutive cycles are independent. Pops on several lanes in the same cycle are all honoured.
- in_valid=0: in_sel and in_data are ignored and no slot changes.
- No beat is dropped or duplicated. Each accepted beat appears exactly once on its lane, in acceptance order per lane.
- flush=1:
  - All slot valid bits clear at the next edge.
  - in_ready=0, so no accept occurs that cycle.
  - Pops in the flush cycle still count if out_valid & out_ready.
  - Flushed beats that were never popped are not counted.
- Reset mid-operation: asserting rst_n=0 immediately clears all slots and counters, regardless of the clock. Any beat in flight is lost.
- out_valid must not drop while out_ready=0 except via flush or reset.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> out_valid=4'b0000, out_count all 0, in_ready=1.
- Single steer: push 8'hA5 with sel=2, out_ready=4'b0000 -> next cycle out_valid=4'b0100, lane2 data=8'hA5. Second push sel=2 -> in_ready=0. Push sel=0 8'h3C -> accepted, out_valid=4'b0101.
- Full throughput: out_ready=4'b1111, stream 0x00..0x0F with sel=i%4 every cycle -> in_ready held 1, each lane receives its 4 beats in order, out_count=4 per lane.
- Same-lane pop+push: lane1 holds 8'h11, out_ready[1]=1, and 8'h22 is pushed to sel=1 in the same cycle -> next cycle lane1 valid=1, data=8'h22, out_count lane1=1.
- Flush: lanes 0 and 3 full, flush=1 with in_valid=1 for one cycle -> in_ready=0, next cycle out_valid=0, counts unchanged.
- Counter wrap with CNT_W=8: pop 256 beats on lane 0 -> out_count lane0 reads 0. Pop one more -> reads 1. Async reset asserted mid-stream clears the lanes immediately.
